// File: rtl/vr16_pkg.sv
// VR16 shared definitions: opcodes, flag bit positions, execute-stage FSM
// encoding and default datapath widths.
package vr16_pkg;

  localparam int DATA_W_DEFAULT = 16;
  localparam int SEL_W_DEFAULT  = 2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_PASS = 4'd9;

  // Bit positions inside the 4-bit {V,C,N,Z} status register.
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_WB   = 2'd2
  } state_t;

endpackage

// File: rtl/alu_exec_if.sv
// Decode-to-execute request bus plus the register-file write port driven
// back by the execute stage.
interface alu_exec_if
  import vr16_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int SEL_W  = SEL_W_DEFAULT
);

  logic              start;
  logic [3:0]        opcode;
  logic [SEL_W-1:0]  dest_reg;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic              busy;
  logic [DATA_W-1:0] alu_result;
  logic [SEL_W-1:0]  select_reg;
  logic              write_enable;
  logic [3:0]        flags;
  logic              illegal_op;

  // Requester side (decode stage / bench).
  modport master (
    output start, opcode, dest_reg, operand_a, operand_b,
    input  busy, alu_result, select_reg, write_enable, flags, illegal_op
  );

  // Execute-stage side.
  modport slave (
    input  start, opcode, dest_reg, operand_a, operand_b,
    output busy, alu_result, select_reg, write_enable, flags, illegal_op
  );

endinterface

// File: rtl/mul_iter.sv
// Iterative unsigned shift-add multiplier. One partial product is added per
// step; 'product' already includes the partial of the current step, so when
// 'done' is high it holds the final 2*DATA_W-bit result.
module mul_iter #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   product,
  output logic                  done
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = $clog2(DATA_W);

  logic [PROD_W-1:0] mcand_r;
  logic [PROD_W-1:0] product_r;
  logic [DATA_W-1:0] mplier_r;
  logic [CNT_W-1:0]  count_r;
  logic [PROD_W-1:0] step_product_s;

  // Running sum plus this step's partial product (multiplicand if LSB set).
  always_comb begin
    step_product_s = product_r;
    if (mplier_r[0]) begin
      step_product_s = product_r + mcand_r;
    end else begin
      step_product_s = product_r;
    end
  end

  assign product = step_product_s;
  assign done    = step && (count_r == CNT_W'(DATA_W - 1));

  // Operand/partial-sum registers: load clears, each step shifts one bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_r   <= '0;
      product_r <= '0;
      mplier_r  <= '0;
      count_r   <= '0;
    end else if (load) begin
      mcand_r   <= {{DATA_W{1'b0}}, a};
      product_r <= '0;
      mplier_r  <= b;
      count_r   <= '0;
    end else if (step) begin
      mcand_r   <= mcand_r << 1;
      product_r <= step_product_s;
      mplier_r  <= mplier_r >> 1;
      count_r   <= count_r + CNT_W'(1);
    end else begin
      mcand_r   <= mcand_r;
      product_r <= product_r;
      mplier_r  <= mplier_r;
      count_r   <= count_r;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// VR16 execute stage. Single-cycle ops are computed straight from the request
// and registered into the write-back port on the accepting edge; MUL runs
// through mul_iter and is registered on the edge of its final step.
module alu_exec
  import vr16_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int SEL_W  = SEL_W_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  alu_exec_if.slave   bus
);

  localparam int SH_W   = $clog2(DATA_W);
  localparam int PROD_W = 2 * DATA_W;
  localparam int MSB    = DATA_W - 1;

  state_t            state_r;
  state_t            next_state_s;
  logic [SEL_W-1:0]  dest_r;
  logic [DATA_W-1:0] alu_result_r;
  logic [SEL_W-1:0]  select_reg_r;
  logic              write_enable_r;
  logic [3:0]        flags_r;
  logic              illegal_op_r;

  logic [DATA_W-1:0] a_s;
  logic [DATA_W-1:0] b_s;
  logic [DATA_W:0]   sum_s;
  logic [DATA_W-1:0] result_s;
  logic              carry_s;
  logic              ovf_s;
  logic              legal_s;
  logic              accept_s;
  logic              is_mul_s;
  logic              mul_load_s;
  logic              mul_step_s;
  logic              mul_done_s;
  logic [PROD_W-1:0] mul_product_s;

  // Packs result-derived and op-specific bits into the {V,C,N,Z} layout.
  function automatic logic [3:0] pack_flags(input logic [DATA_W-1:0] r,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_Z] = (r == '0);
    f[FLAG_N] = r[DATA_W-1];
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  assign a_s        = bus.operand_a;
  assign b_s        = bus.operand_b;
  assign accept_s   = (state_r == ST_IDLE) && bus.start;
  assign is_mul_s   = (bus.opcode == OP_MUL);
  assign mul_load_s = accept_s && is_mul_s;
  assign mul_step_s = (state_r == ST_MUL);

  mul_iter #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .load    (mul_load_s),
    .step    (mul_step_s),
    .a       (a_s),
    .b       (b_s),
    .product (mul_product_s),
    .done    (mul_done_s)
  );

  // Single-cycle datapath and opcode legality check.
  always_comb begin
    sum_s    = '0;
    result_s = '0;
    carry_s  = 1'b0;
    ovf_s    = 1'b0;
    legal_s  = 1'b1;
    case (bus.opcode)
      OP_ADD: begin
        sum_s    = {1'b0, a_s} + {1'b0, b_s};
        result_s = sum_s[DATA_W-1:0];
        carry_s  = sum_s[DATA_W];
        ovf_s    = (a_s[MSB] == b_s[MSB]) && (result_s[MSB] != a_s[MSB]);
      end
      OP_SUB: begin
        // Bit DATA_W of the widened difference is the unsigned borrow.
        sum_s    = {1'b0, a_s} - {1'b0, b_s};
        result_s = sum_s[DATA_W-1:0];
        carry_s  = sum_s[DATA_W];
        ovf_s    = (a_s[MSB] != b_s[MSB]) && (result_s[MSB] != a_s[MSB]);
      end
      OP_AND:  result_s = a_s & b_s;
      OP_OR:   result_s = a_s | b_s;
      OP_XOR:  result_s = a_s ^ b_s;
      OP_NOT:  result_s = ~a_s;
      OP_SHL:  result_s = a_s << b_s[SH_W-1:0];
      OP_SHR:  result_s = a_s >> b_s[SH_W-1:0];
      OP_MUL:  result_s = '0;
      OP_PASS: result_s = b_s;
      default: legal_s  = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && legal_s) begin
          if (is_mul_s) begin
            next_state_s = ST_MUL;
          end else begin
            next_state_s = ST_WB;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_done_s) begin
          next_state_s = ST_WB;
        end else begin
          next_state_s = ST_MUL;
        end
      end
      ST_WB:   next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Write-back port, status flags and illegal-op strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      dest_r         <= '0;
      alu_result_r   <= '0;
      select_reg_r   <= '0;
      write_enable_r <= 1'b0;
      flags_r        <= 4'b0000;
      illegal_op_r   <= 1'b0;
    end else begin
      write_enable_r <= 1'b0;
      illegal_op_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (!legal_s) begin
              illegal_op_r <= 1'b1;
            end else if (is_mul_s) begin
              dest_r <= bus.dest_reg;
            end else begin
              alu_result_r   <= result_s;
              select_reg_r   <= bus.dest_reg;
              write_enable_r <= 1'b1;
              flags_r        <= pack_flags(result_s, carry_s, ovf_s);
            end
          end else begin
            dest_r <= dest_r;
          end
        end
        ST_MUL: begin
          if (mul_done_s) begin
            alu_result_r   <= mul_product_s[DATA_W-1:0];
            select_reg_r   <= dest_r;
            write_enable_r <= 1'b1;
            flags_r        <= pack_flags(mul_product_s[DATA_W-1:0],
                                         |mul_product_s[PROD_W-1:DATA_W], 1'b0);
          end else begin
            dest_r <= dest_r;
          end
        end
        ST_WB:   dest_r <= dest_r;
        default: dest_r <= dest_r;
      endcase
    end
  end

  assign bus.busy         = (state_r != ST_IDLE);
  assign bus.alu_result   = alu_result_r;
  assign bus.select_reg   = select_reg_r;
  assign bus.write_enable = write_enable_r;
  assign bus.flags        = flags_r;
  assign bus.illegal_op   = illegal_op_r;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: scoreboard of expected write-backs,
// popped by a monitor on every write strobe, plus per-scenario timing checks.
module tb_alu_exec;
  import vr16_pkg::*;

  typedef struct packed {
    logic [15:0] r;
    logic [1:0]  sel;
    logic [3:0]  f;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  exp_t sb_q[$];
  exp_t mon_e;
  logic [3:0] last_flags_exp;

  alu_exec_if #(.DATA_W(16), .SEL_W(2)) bus ();

  alu_exec #(.DATA_W(16), .SEL_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: returns {flags[3:0], result[15:0]}.
  function automatic logic [19:0] model(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [31:0] w;
    logic [15:0] r;
    logic c;
    logic v;
    int sa;
    int sb;
    int s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    c = 1'b0;
    v = 1'b0;
    r = 16'h0000;
    w = 32'h0;
    case (op)
      4'd0: begin w = {16'h0, a} + {16'h0, b}; r = w[15:0]; c = w[16];
                  s = sa + sb; v = (s > 32767) || (s < -32768); end
      4'd1: begin r = a - b; c = (a < b); s = sa - sb; v = (s > 32767) || (s < -32768); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: r = a << b[3:0];
      4'd7: r = a >> b[3:0];
      4'd8: begin w = {16'h0, a} * {16'h0, b}; r = w[15:0]; c = (w[31:16] != 16'h0); end
      4'd9: r = b;
      default: r = 16'h0000;
    endcase
    return {v, c, r[15], (r == 16'h0000), r};
  endfunction

  // Scoreboard consumer: every write strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.write_enable === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got result=%h sel=%0d, required no write",
                 bus.alu_result, bus.select_reg);
      end else begin
        mon_e = sb_q.pop_front();
        if (bus.alu_result !== mon_e.r || bus.select_reg !== mon_e.sel ||
            bus.flags !== mon_e.f) begin
          failures++;
          $display("FAIL writeback got r=%h sel=%0d f=%b, required r=%h sel=%0d f=%b",
                   bus.alu_result, bus.select_reg, bus.flags, mon_e.r, mon_e.sel, mon_e.f);
        end
      end
    end
  end

  task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] d);
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = op; bus.operand_a = a; bus.operand_b = b; bus.dest_reg = d;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic do_single(input string name, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [1:0] d,
                           input logic [15:0] exp_r, input logic [3:0] exp_f);
    sb_q.push_back('{r: exp_r, sel: d, f: exp_f});
    last_flags_exp = exp_f;
    drive(op, a, b, d);
    checks++;
    if (bus.write_enable !== 1'b1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_latency got we=%b busy=%b, required we=1 busy=1", name,
               bus.write_enable, bus.busy);
    end
    @(negedge clk);
    checks++;
    if (bus.write_enable !== 1'b0 || bus.busy !== 1'b0 || bus.alu_result !== exp_r) begin
      failures++;
      $display("FAIL %s_after got we=%b busy=%b r=%h, required we=0 busy=0 r=%h", name,
               bus.write_enable, bus.busy, bus.alu_result, exp_r);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.write_enable !== 1'b0 || bus.illegal_op !== 1'b0 ||
        bus.alu_result !== 16'h0 || bus.select_reg !== 2'd0 || bus.flags !== 4'b0) begin
      failures++;
      $display("FAIL reset_state got busy=%b we=%b ill=%b r=%h sel=%0d f=%b, required all 0",
               bus.busy, bus.write_enable, bus.illegal_op, bus.alu_result, bus.select_reg,
               bus.flags);
    end
    reset = 1'b0;
    last_flags_exp = 4'b0000;
  endtask

  task automatic test_arith();
    do_single("add_ovf",  OP_ADD, 16'h7FFF, 16'h0001, 2'd2, 16'h8000, 4'b1010);
    do_single("sub_borrow", OP_SUB, 16'h0003, 16'h0005, 2'd1, 16'hFFFE, 4'b0110);
    do_single("sub_zero", OP_SUB, 16'h0005, 16'h0005, 2'd0, 16'h0000, 4'b0001);
    do_single("add_carry", OP_ADD, 16'hFFFF, 16'h0001, 2'd3, 16'h0000, 4'b0101);
    do_single("sub_ovf",  OP_SUB, 16'h8000, 16'h0001, 2'd1, 16'h7FFF, 4'b1000);
  endtask

  task automatic test_logic_shift();
    do_single("shl15", OP_SHL,  16'h0001, 16'h000F, 2'd0, 16'h8000, 4'b0010);
    do_single("shr4",  OP_SHR,  16'h8000, 16'h0004, 2'd1, 16'h0800, 4'b0000);
    do_single("shl0",  OP_SHL,  16'hABCD, 16'h0000, 2'd2, 16'hABCD, 4'b0010);
    do_single("not",   OP_NOT,  16'h00FF, 16'h0000, 2'd3, 16'hFF00, 4'b0010);
    do_single("pass",  OP_PASS, 16'hDEAD, 16'h1234, 2'd0, 16'h1234, 4'b0000);
    do_single("and",   OP_AND,  16'hF0F0, 16'hFF00, 2'd1, 16'hF000, 4'b0010);
    do_single("or",    OP_OR,   16'h0F00, 16'h00F0, 2'd2, 16'h0FF0, 4'b0000);
    do_single("xor",   OP_XOR,  16'hFFFF, 16'hFFFF, 2'd3, 16'h0000, 4'b0001);
  endtask

  task automatic test_mul();
    int busy_cnt;
    int we_cnt;
    int we_at;
    busy_cnt = 0; we_cnt = 0; we_at = -1;
    sb_q.push_back('{r: 16'h2300, sel: 2'd3, f: 4'b0100});
    last_flags_exp = 4'b0100;
    drive(OP_MUL, 16'h0123, 16'h0100, 2'd3);
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.write_enable === 1'b1) begin
        we_cnt++;
        we_at = k;
      end
      // Requests while busy must be dropped, not queued.
      bus.start  = (k >= 2 && k <= 4) ? 1'b1 : 1'b0;
      bus.opcode = OP_ADD;
    end
    checks++;
    if (busy_cnt != 17 || we_cnt != 1 || we_at != 16) begin
      failures++;
      $display("FAIL mul_timing got busy_cycles=%0d writes=%0d write_at=%0d, required 17 1 16",
               busy_cnt, we_cnt, we_at);
    end
  endtask

  task automatic test_illegal();
    drive(4'd12, 16'h1111, 16'h2222, 2'd1);
    checks++;
    if (bus.illegal_op !== 1'b1 || bus.write_enable !== 1'b0 || bus.busy !== 1'b0 ||
        bus.flags !== last_flags_exp) begin
      failures++;
      $display("FAIL illegal_pulse got ill=%b we=%b busy=%b f=%b, required 1 0 0 f=%b",
               bus.illegal_op, bus.write_enable, bus.busy, bus.flags, last_flags_exp);
    end
    @(negedge clk);
    checks++;
    if (bus.illegal_op !== 1'b0) begin
      failures++;
      $display("FAIL illegal_width got ill=%b, required 0", bus.illegal_op);
    end
  endtask

  task automatic test_back_to_back();
    sb_q.push_back('{r: 16'h0030, sel: 2'd1, f: 4'b0000});
    sb_q.push_back('{r: 16'h0F0F, sel: 2'd2, f: 4'b0000});
    last_flags_exp = 4'b0000;
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = OP_ADD; bus.operand_a = 16'h0010;
    bus.operand_b = 16'h0020; bus.dest_reg = 2'd1;
    @(negedge clk);
    bus.opcode = OP_PASS; bus.operand_b = 16'h0F0F; bus.dest_reg = 2'd2;
    @(negedge clk);
    checks++;
    if (bus.write_enable !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_gap got we=%b busy=%b, required 0 0", bus.write_enable, bus.busy);
    end
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.write_enable !== 1'b1) begin
      failures++;
      $display("FAIL b2b_second got we=%b, required 1", bus.write_enable);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    drive(OP_MUL, 16'h1234, 16'h0007, 2'd2);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.write_enable !== 1'b0 || bus.alu_result !== 16'h0 ||
        bus.select_reg !== 2'd0 || bus.flags !== 4'b0 || bus.illegal_op !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got busy=%b we=%b r=%h sel=%0d f=%b, required all 0",
               bus.busy, bus.write_enable, bus.alu_result, bus.select_reg, bus.flags);
    end
    reset = 1'b0;
    last_flags_exp = 4'b0000;
    do_single("add_after_reset", OP_ADD, 16'h0002, 16'h0003, 2'd1, 16'h0005, 4'b0000);
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  d;
    logic [19:0] m;
    int waited;
    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(0, 9));
      a  = 16'($urandom());
      b  = 16'($urandom());
      d  = 2'($urandom_range(0, 3));
      m  = model(op, a, b);
      sb_q.push_back('{r: m[15:0], sel: d, f: m[19:16]});
      drive(op, a, b, d);
      waited = 0;
      while (bus.busy === 1'b1 && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      checks++;
      if (bus.busy !== 1'b0 || bus.alu_result !== m[15:0]) begin
        failures++;
        $display("FAIL random_%0d op=%0d got busy=%b r=%h, required busy=0 r=%h", i, op,
                 bus.busy, bus.alu_result, m[15:0]);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.opcode = 4'd0; bus.dest_reg = 2'd0;
    bus.operand_a = 16'h0000; bus.operand_b = 16'h0000;
    test_reset();
    test_arith();
    test_logic_shift();
    test_mul();
    test_illegal();
    test_back_to_back();
    test_reset_mid_mul();
    test_random();
    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL missing_writes got pending=%0d, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
